// File: rtl/map_pkg.sv
// rtl/map_pkg.sv - tile codes, FSM encoding and helpers shared by the level sequencer
//
// Purpose: common definitions for level_ctl and its neighbours on the map path.
// Ports:   none (package).
package map_pkg;

   localparam int MAP_COLS = 15;
   localparam int MAP_ROWS = 10;

   typedef enum logic [3:0] {
      BLANK   = 4'd0,
      WALL    = 4'd1,
      COIN    = 4'd2,
      POWERUP = 4'd3
   } tile_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PLAY,
      ST_CLEAR,
      ST_WON
   } state_e;

   function automatic logic is_collectible(input logic [3:0] code);
      return (code == COIN) || (code == POWERUP);
   endfunction

endpackage

// File: rtl/level_ctl.sv
// rtl/level_ctl.sv - level sequencer: loads tile maps from ROM, tracks collectibles, advances levels
//
// Purpose: copies each level's tile map from a synchronous 1-cycle level ROM into the flat map
//          bus, counts COIN/POWERUP tiles, consumes pickup events and steps through the levels.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               pulse, (re)start at level 0 (ignored while loading)
//   pickup_valid/idx    hero collected tile idx = x + y*15
//   rom_addr/rom_data   level ROM interface, data returns one cycle after address
//   map                 tile i at map[i*TILE_W +: TILE_W]
//   map_valid           high in PLAY only
//   busy                high in LOAD and CLEAR
//   level               current level index
//   coins_left          uncollected COIN+POWERUP tiles of the current level
//   level_done          one-cycle pulse when the level is cleared
//   game_won            held high after the last level is cleared
// Configuration:
//   LEVEL_CTL_CLEAR_PICKED_EN  accepted pickups also overwrite their map tile with BLANK
module level_ctl
   import map_pkg::*;
#(
   parameter int TILES       = MAP_COLS * MAP_ROWS,
   parameter int TILE_W      = 4,
   parameter int NUM_LEVELS  = 4,
   parameter int ROM_AW      = 10,
   parameter int CLEAR_DELAY = 1200000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      pickup_valid,
   input  logic [7:0]                pickup_idx,
   output logic [ROM_AW-1:0]         rom_addr,
   input  logic [TILE_W-1:0]         rom_data,
   output logic [TILES*TILE_W-1:0]   map,
   output logic                      map_valid,
   output logic                      busy,
   output logic [1:0]                level,
   output logic [7:0]                coins_left,
   output logic                      level_done,
   output logic                      game_won
);

   localparam logic [7:0] TILES_B = 8'(TILES);
   localparam int         MAP_IW  = $clog2(TILES * TILE_W);

   state_e              state, next_state;
   logic [7:0]          k;
   logic [31:0]         timer;
   logic [TILES-1:0]    seen;
   logic [ROM_AW-1:0]   rom_addr_q;
   logic [7:0]          pick_sel;
   logic [MAP_IW-1:0]   pick_base;
   logic [MAP_IW-1:0]   wr_base;
   logic [TILE_W-1:0]   pick_code;
   logic                pick_in_range;
   logic                accept;
   logic                enter_load;
   logic                last_level;
   logic                clear_done;

   // Out-of-range indices are steered to tile 0 so the map read stays in bounds;
   // pick_in_range still rejects them.
   assign pick_in_range = (pickup_idx < TILES_B);
   assign pick_sel      = pick_in_range ? pickup_idx : 8'd0;
   assign pick_base     = MAP_IW'(int'(pick_sel) * TILE_W);
   assign wr_base       = MAP_IW'((int'(k) - 1) * TILE_W);
   assign pick_code     = map[pick_base +: TILE_W];

   // start takes priority over a same-cycle pickup; coins_left != 0 guards underflow.
   assign accept = (state == ST_PLAY) && !start && pickup_valid && pick_in_range &&
                   is_collectible(pick_code) && !seen[pick_sel] && (coins_left != 8'd0);

   assign last_level = (level == 2'(NUM_LEVELS - 1));
   assign clear_done = (timer == 32'(CLEAR_DELAY - 1));
   assign enter_load = (next_state == ST_LOAD) && (state != ST_LOAD);

   assign map_valid = (state == ST_PLAY);
   assign busy      = (state == ST_LOAD) || (state == ST_CLEAR);
   assign game_won  = (state == ST_WON);

   // Address is live during the fetch phase of LOAD and otherwise holds its last value.
   assign rom_addr = ((state == ST_LOAD) && (k != TILES_B))
                   ? ROM_AW'(int'(level) * TILES + int'(k))
                   : rom_addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      level_done = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) next_state = ST_LOAD;
         end
         ST_LOAD: begin
            if (k == TILES_B) next_state = ST_PLAY;
         end
         ST_PLAY: begin
            if (start) begin
               next_state = ST_LOAD;
            end else if (coins_left == 8'd0) begin
               level_done = 1'b1;
               next_state = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            if (start) begin
               next_state = ST_LOAD;
            end else if (clear_done) begin
               next_state = last_level ? ST_WON : ST_LOAD;
            end
         end
         ST_WON: begin
            if (start) next_state = ST_LOAD;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         map        <= '0;
         rom_addr_q <= '0;
         level      <= '0;
         coins_left <= '0;
         seen       <= '0;
         k          <= '0;
         timer      <= '0;
      end else begin
         rom_addr_q <= rom_addr;
         timer      <= (state == ST_CLEAR) ? timer + 32'd1 : 32'd0;
         if (enter_load) begin
            k          <= '0;
            coins_left <= '0;
            seen       <= '0;
            // Only the timed exit of CLEAR advances; every start-driven entry restarts at 0.
            level      <= ((state == ST_CLEAR) && !start) ? level + 2'd1 : 2'd0;
         end else begin
            case (state)
               ST_IDLE: level <= '0;
               ST_LOAD: begin
                  k <= k + 8'd1;
                  // rom_data lags rom_addr by one cycle, so cycle k delivers tile k-1.
                  if (k != 8'd0) begin
                     map[wr_base +: TILE_W] <= rom_data;
                     if (is_collectible(rom_data)) coins_left <= coins_left + 8'd1;
                  end
               end
               ST_PLAY: begin
                  if (accept) begin
                     seen[pick_sel] <= 1'b1;
                     coins_left     <= coins_left - 8'd1;
`ifdef LEVEL_CTL_CLEAR_PICKED_EN
                     map[pick_base +: TILE_W] <= TILE_W'(BLANK);
`endif
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_level_ctl.sv
// tb/tb_level_ctl.sv - randomized self-checking bench for level_ctl with a behavioural map model
module tb_level_ctl;

   localparam int NT = 150;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         pickup_valid;
   logic [7:0]   pickup_idx;
   logic [9:0]   rom_addr;
   logic [3:0]   rom_data;
   logic [599:0] map;
   logic         map_valid;
   logic         busy;
   logic [1:0]   level;
   logic [7:0]   coins_left;
   logic         level_done;
   logic         game_won;

   level_ctl #(
      .TILES(150), .TILE_W(4), .NUM_LEVELS(4), .ROM_AW(10), .CLEAR_DELAY(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .pickup_valid(pickup_valid), .pickup_idx(pickup_idx),
      .rom_addr(rom_addr), .rom_data(rom_data), .map(map),
      .map_valid(map_valid), .busy(busy), .level(level),
      .coins_left(coins_left), .level_done(level_done), .game_won(game_won)
   );

   always #5 clk = ~clk;

   logic [3:0] rom [0:1023];
   always @(posedge clk) rom_data <= rom[rom_addr];

   logic [3:0] cur_map [0:NT-1];
   bit         seen    [0:NT-1];
   int         exp_coins;
   int         vectors = 0;
   int         miscompares = 0;

   function automatic bit coll(input logic [3:0] c);
      return (c == 4'd2) || (c == 4'd3);
   endfunction

   function automatic logic [3:0] bg_tile();
      int v;
      v = int'($urandom_range(0, 13));
      return (v < 2) ? 4'(v) : 4'(v + 2);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_map(input string tag);
      logic [599:0] e;
      for (int i = 0; i < NT; i++) e[i*4 +: 4] = cur_map[i];
      vectors++;
      assert (map === e) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, map, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load_model(input int lvl);
      exp_coins = 0;
      for (int i = 0; i < NT; i++) begin
         cur_map[i] = rom[lvl*NT + i];
         seen[i]    = 1'b0;
         if (coll(cur_map[i])) exp_coins++;
      end
   endtask

   // Called at the negedge just after LOAD was entered (k = 0).
   task automatic wait_load(input int lvl, input bit poke);
      int n;
      n = 0;
      chk("load_busy", 32'(busy), 32'd1);
      chk("load_level", 32'(level), 32'(lvl));
      if (poke) begin
         pickup_valid = 1'b1;
         pickup_idx   = 8'd5;
      end
      while (map_valid !== 1'b1 && n < 400) begin
         if (n == 0 || n == 75 || n == 149)
            chk("load_rom_addr", 32'(rom_addr), 32'(lvl*NT + n));
         tick();
         n++;
      end
      pickup_valid = 1'b0;
      load_model(lvl);
      chk("load_cycles", 32'(n), 32'd151);
      chk("load_coins", 32'(coins_left), 32'(exp_coins));
      chk_map("load_map");
   endtask

   task automatic do_pick(input int idx);
      pickup_valid = 1'b1;
      pickup_idx   = 8'(idx);
      tick();
      pickup_valid = 1'b0;
      if (idx < NT && exp_coins > 0) begin
         if (coll(cur_map[idx]) && !seen[idx]) begin
            seen[idx] = 1'b1;
            exp_coins--;
`ifdef LEVEL_CTL_CLEAR_PICKED_EN
            cur_map[idx] = 4'd0;
`endif
         end
      end
      chk("pick_coins", 32'(coins_left), 32'(exp_coins));
   endtask

   task automatic play_level();
      int steps;
      int idx;
      steps = 0;
      while (exp_coins > 0 && steps < 3000) begin
         if ($urandom_range(0, 3) == 0) begin
            idx = int'($urandom_range(0, 255));
         end else begin
            idx = int'($urandom_range(0, NT - 1));
            while (!(coll(cur_map[idx]) && !seen[idx])) idx = (idx + 1) % NT;
         end
         do_pick(idx);
         steps++;
      end
      chk("play_coins_zero", 32'(coins_left), 32'd0);
      chk("level_done_pulse", 32'(level_done), 32'd1);
      chk("play_map_valid", 32'(map_valid), 32'd1);
   endtask

   // Called at the negedge where level_done was seen.
   task automatic finish_level(input int lvl);
      tick();
      chk("clear_done_low", 32'(level_done), 32'd0);
      chk("clear_busy", 32'(busy), 32'd1);
      chk("clear_map_valid", 32'(map_valid), 32'd0);
      chk("clear_level", 32'(level), 32'(lvl));
      tick();
      if (lvl < 3) begin
         wait_load(lvl + 1, 1'b0);
      end else begin
         chk("won_flag", 32'(game_won), 32'd1);
         chk("won_busy", 32'(busy), 32'd0);
         chk("won_map_valid", 32'(map_valid), 32'd0);
         chk("won_level", 32'(level), 32'd3);
         chk_map("won_map");
      end
   endtask

   initial begin
      // ROM image: level 0 directed (2 COIN + 1 POWERUP), 1/3 random, 2 without collectibles.
      for (int a = 0; a < 1024; a++) rom[a] = 4'd0;
      for (int i = 0; i < NT; i++) begin
         rom[i]        = bg_tile();
         rom[NT + i]   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(2, 3)) : bg_tile();
         rom[2*NT + i] = bg_tile();
         rom[3*NT + i] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(2, 3)) : bg_tile();
      end
      rom[0]        = 4'd1;
      rom[5]        = 4'd2;
      rom[37]       = 4'd2;
      rom[149]      = 4'd3;
      rom[NT]       = 4'd2;
      rom[4*NT - 1] = 4'd2;

      rst_n = 1'b0;
      start = 1'b0;
      pickup_valid = 1'b0;
      pickup_idx = 8'd0;
      tick();
      tick();
      chk("rst_map", 32'(map == '0), 32'd1);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_coins", 32'(coins_left), 32'd0);
      chk("rst_flags", {28'd0, map_valid, busy, level_done, game_won}, 32'd0);

      rst_n = 1'b1;
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_load(0, 1'b1);
      chk("lvl0_coins3", 32'(coins_left), 32'd3);

      do_pick(5);
      chk("pick5_tile", 32'(map[23:20]), 32'(cur_map[5]));
      chk_map("pick5_map");
      do_pick(5);
      do_pick(200);
      do_pick(0);
      chk("lvl0_coins2", 32'(coins_left), 32'd2);
      play_level();
      finish_level(0);
      play_level();
      finish_level(1);
      play_level();
      finish_level(2);
      play_level();
      finish_level(3);

      tick();
      tick();
      chk("won_hold", 32'(game_won), 32'd1);
      pickup_valid = 1'b1;
      pickup_idx = 8'd0;
      tick();
      pickup_valid = 1'b0;
      chk("won_pick_ignored", 32'(coins_left), 32'd0);

      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_level", 32'(level), 32'd0);
      chk("restart_coins", 32'(coins_left), 32'd0);
      chk("restart_won_low", 32'(game_won), 32'd0);
      wait_load(0, 1'b0);

      // start and pickup in the same PLAY cycle: start wins.
      start = 1'b1;
      pickup_valid = 1'b1;
      pickup_idx = 8'd5;
      tick();
      start = 1'b0;
      pickup_valid = 1'b0;
      chk("startwin_busy", 32'(busy), 32'd1);
      chk("startwin_coins", 32'(coins_left), 32'd0);
      wait_load(0, 1'b0);
      chk("startwin_reload", 32'(coins_left), 32'd3);
      play_level();

      tick();
      tick();
      chk("lvl1_reload_level", 32'(level), 32'd1);
      for (int i = 0; i < 70; i++) tick();
      chk("k70_rom_addr", 32'(rom_addr), 32'd220);
      #2 rst_n = 1'b0;
      #1;
      chk("async_map", 32'(map == '0), 32'd1);
      chk("async_level", 32'(level), 32'd0);
      chk("async_coins", 32'(coins_left), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_rom_addr", 32'(rom_addr), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      chk("post_rst_idle", {30'd0, busy, map_valid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
